param_reservation_station: RTL
==============================

PARAM_RESERVATION_STATION -- requirements
Module: param_reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries, legal 2..8.
REQ-002 SHALL have parameter DW, default 32: operand data width.
REQ-003 SHALL have parameter LW, default 4: label width; label 0 means "operand valid, no producer".
REQ-004 SHALL have parameter OPW, default 6: opcode width.
REQ-005 SHALL have parameter BASE_LABEL, default 1: tag of entry i is BASE_LABEL+i; BASE_LABEL+DEPTH-1 < 2^LW, and BASE_LABEL >= 1.
REQ-006 SHALL have port clk  in  1: single clock, rising edge.
REQ-007 SHALL have port nRST  in  1: reset, asynchronous, active-low.
REQ-008 SHALL have port flush  in  1: synchronous clear of all entries.
REQ-009 SHALL have port WEN  in  1: dispatch write request.
REQ-010 SHALL have ports opCode  in  OPW; dataIn1, dataIn2  in  DW; label1, label2  in  LW: dispatched op and operands.
REQ-011 SHALL have port labelAlloc  out  LW: tag the next accepted dispatch receives.
REQ-012 SHALL have port isFull  out  1: all entries valid.
REQ-013 SHALL have port count  out  4: number of valid entries.
REQ-014 SHALL have ports BCEN  in  1; BClabel  in  LW; BCdata  in  DW: common-data-bus broadcast.
REQ-015 SHALL have port EXEable  in  1: downstream unit accepts an issue this cycle.
REQ-016 SHALL have ports OutEn  out  1; opOut  out  OPW; dataOut1, dataOut2  out  DW; labelOut  out  LW: issue channel.

Function
REQ-017 SHALL accept a dispatch when WEN=1, isFull=0, flush=0: writes lowest-index free entry at the rising edge; WEN while full SHALL change no state.
REQ-018 SHALL drive labelAlloc combinationally = BASE_LABEL + lowest free index; 0 when full.
REQ-019 SHALL derive isFull and count from registered state only; a slot freed by issue in cycle N is allocatable in cycle N+1.
REQ-020 SHALL, when BCEN=1 and BClabel!=0, for every valid entry whose label1 (label2) equals BClabel, load BCdata into data1 (data2) and clear that label to 0 at the edge; BClabel=0 ignored.
REQ-021 SHALL bypass at dispatch: if BCEN=1 and incoming label1/label2 equals BClabel (nonzero), the entry stores BCdata and label 0 for that operand.
REQ-022 SHALL mark an entry ready when valid and both labels are 0; ready status is registered, so a dispatched or woken entry issues no earlier than the next cycle.
REQ-023 SHALL drive OutEn=1 combinationally whenever any entry is ready, selecting the oldest ready entry by allocation order, not by index.
REQ-024 SHALL present on issue: opOut, dataOut1, dataOut2 of the selected entry, labelOut = its tag; all issue outputs 0 when OutEn=0.
REQ-025 SHALL free the selected entry at the edge when OutEn=1 and EXEable=1; otherwise the entry and selection hold.
REQ-026 SHALL allow dispatch, broadcast, and issue in the same cycle, each applied independently; a dispatch never reuses the slot issued in that cycle.
REQ-027 SHALL, on flush=1, invalidate all entries at the edge with priority over WEN, issue, and broadcast; count=0 next cycle.
REQ-028 SHALL maintain allocation order across wrap of any internal age counter, for any DEPTH.

Reset
REQ-029 SHALL, on nRST=0, immediately invalidate all entries and drive OutEn=0, isFull=0, count=0, labelAlloc=BASE_LABEL, and all issue outputs 0, independent of clk.
REQ-030 SHALL resume accepting dispatch on the first rising edge after nRST returns to 1.

Verification (DEPTH=4, BASE_LABEL=1)
REQ-031 SHALL pass: dispatch op=3, data 5/7, labels 0/0 -> labelAlloc=1 that cycle; next cycle OutEn=1, opOut=3, dataOut1=5, dataOut2=7, labelOut=1; EXEable=1 -> count=0 following cycle.
REQ-032 SHALL pass: dispatch label1=6 to tag 1; later BCEN=1, BClabel=6, BCdata=0x10 -> next cycle OutEn=1, dataOut1=0x10; same broadcast coinciding with the dispatch cycle -> identical result (bypass).
REQ-033 SHALL pass: 4 dispatches -> isFull=1, count=4, labelAlloc=0; 5th WEN ignored; issue with EXEable=1 -> isFull=0 next cycle, labelAlloc = freed tag.
REQ-034 SHALL pass: tag1 waiting (label1=9), tag2, tag3 ready -> issue order 2, 3; new ready dispatch into freed tag2 issues after tag3; BClabel=9 then issues tag1.
REQ-035 SHALL pass: 3 valid entries, flush=1 together with WEN=1 -> count=0, OutEn=0 next cycle; nRST pulsed low mid-cycle -> outputs reset before next edge.

Source files
------------

// File: rtl/param_reservation_station.sv
// rtl/param_reservation_station.sv - parameterized reservation station with CDB wakeup and oldest-ready issue
// Operands wait on producer labels; the issue pick follows allocation order held in an age matrix.
module param_reservation_station #(
  parameter int DEPTH      = 4,
  parameter int DW         = 32,
  parameter int LW         = 4,
  parameter int OPW        = 6,
  parameter int BASE_LABEL = 1
) (
  input  logic           clk,
  input  logic           nRST,
  input  logic           flush,
  input  logic           WEN,
  input  logic [OPW-1:0] opCode,
  input  logic [DW-1:0]  dataIn1,
  input  logic [DW-1:0]  dataIn2,
  input  logic [LW-1:0]  label1,
  input  logic [LW-1:0]  label2,
  output logic [LW-1:0]  labelAlloc,
  output logic           isFull,
  output logic [3:0]     count,
  input  logic           BCEN,
  input  logic [LW-1:0]  BClabel,
  input  logic [DW-1:0]  BCdata,
  input  logic           EXEable,
  output logic           OutEn,
  output logic [OPW-1:0] opOut,
  output logic [DW-1:0]  dataOut1,
  output logic [DW-1:0]  dataOut2,
  output logic [LW-1:0]  labelOut
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [OPW-1:0]   op_q  [DEPTH];
  logic [DW-1:0]    d1_q  [DEPTH];
  logic [DW-1:0]    d2_q  [DEPTH];
  logic [LW-1:0]    l1_q  [DEPTH];
  logic [LW-1:0]    l2_q  [DEPTH];
  // older[i][j] set means entry i was allocated before entry j; no counter, so nothing wraps
  logic [DEPTH-1:0] older [DEPTH];

  logic [DEPTH-1:0] ready;
  logic [IW-1:0]    free_idx;
  logic             has_free;
  logic [IW-1:0]    sel;
  logic             any_ready;
  logic             blocked;
  logic             bc_hit;
  logic             do_issue;
  logic             do_alloc;

  always_comb begin
    free_idx = '0;
    has_free = 1'b0;
    count    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IW'(i);
        has_free = 1'b1;
      end
      count = count + {3'b000, valid[i]};
      ready[i] = valid[i] && (l1_q[i] == '0) && (l2_q[i] == '0);
    end
  end

  assign isFull     = ~has_free;
  assign labelAlloc = has_free ? (LW'(BASE_LABEL) + LW'(free_idx)) : '0;

  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    blocked   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked && !any_ready) begin
        sel       = IW'(i);
        any_ready = 1'b1;
      end
    end
  end

  assign OutEn    = any_ready;
  assign opOut    = any_ready ? op_q[sel] : '0;
  assign dataOut1 = any_ready ? d1_q[sel] : '0;
  assign dataOut2 = any_ready ? d2_q[sel] : '0;
  assign labelOut = any_ready ? (LW'(BASE_LABEL) + LW'(sel)) : '0;

  assign bc_hit   = BCEN && (BClabel != '0);
  assign do_issue = any_ready && EXEable;
  assign do_alloc = WEN && has_free;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        d1_q[i]  <= '0;
        d2_q[i]  <= '0;
        l1_q[i]  <= '0;
        l2_q[i]  <= '0;
        older[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && bc_hit && l1_q[i] == BClabel) begin
          d1_q[i] <= BCdata;
          l1_q[i] <= '0;
        end
        if (valid[i] && bc_hit && l2_q[i] == BClabel) begin
          d2_q[i] <= BCdata;
          l2_q[i] <= '0;
        end
      end
      if (do_issue) valid[sel] <= 1'b0;
      // The free slot was invalid at the start of the cycle, so it can never be the one issuing
      if (do_alloc) begin
        valid[free_idx] <= 1'b1;
        op_q[free_idx]  <= opCode;
        d1_q[free_idx]  <= (bc_hit && label1 == BClabel) ? BCdata : dataIn1;
        l1_q[free_idx]  <= (bc_hit && label1 == BClabel) ? '0 : label1;
        d2_q[free_idx]  <= (bc_hit && label2 == BClabel) ? BCdata : dataIn2;
        l2_q[free_idx]  <= (bc_hit && label2 == BClabel) ? '0 : label2;
        for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= 1'b1;
        older[free_idx] <= '0;
      end
    end
  end

endmodule
